// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer around an external combinational 8-bit ALU
// Latches operands, waits SETTLE_CYCLES for the ALU to settle, then holds the result until it is consumed.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic [7:0] op_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_sequencer: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [7:0] acc;
    logic       accept;
    logic       settle_done;
    logic       res_fire;

    // Handshake outputs are pure state decodes so cmd_valid never reaches cmd_ready.
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == RESP);

    assign accept      = cmd_ready && cmd_valid;
    assign settle_done = (state == SETTLE) && (settle_cnt == 4'd0);
    assign res_fire    = res_valid && res_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = RESP;
            RESP:    if (res_fire)    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            acc        <= 8'h00;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_op     <= 2'b00;
            res_data   <= 8'h00;
            op_count   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= cmd_use_acc ? acc : cmd_a;
                alu_b      <= cmd_b;
                alu_op     <= cmd_op;
                settle_cnt <= SETTLE_LOAD;
            end
            if (state == SETTLE) begin
                if (settle_done) begin
                    res_data <= alu_result;
                    acc      <= alu_result;
                end else begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
            // op_count wraps naturally at 8 bits.
            if (res_fire) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
// Two instances (SETTLE_CYCLES 1 and 4) share stimulus; sel picks which one is driven and observed.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       sel;
    logic       rst_n1, rst_n4;
    logic       cmd_valid, cmd_use_acc, res_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;

    logic       cmd_ready1, res_valid1, busy1, cmd_ready4, res_valid4, busy4;
    logic [7:0] alu_a1, alu_b1, res_data1, op_count1, alu_result1;
    logic [7:0] alu_a4, alu_b4, res_data4, op_count4, alu_result4;
    logic [1:0] alu_op1, alu_op4;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result1 = alu_model(alu_a1, alu_b1, alu_op1);
    assign alu_result4 = alu_model(alu_a4, alu_b4, alu_op4);

    alu_sequencer #(.SETTLE_CYCLES(1)) u_seq1 (
        .clk(clk), .rst_n(rst_n1),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
        .res_valid(res_valid1), .res_ready(res_ready & ~sel), .res_data(res_data1),
        .busy(busy1), .op_count(op_count1)
    );

    alu_sequencer #(.SETTLE_CYCLES(4)) u_seq4 (
        .clk(clk), .rst_n(rst_n4),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_result4),
        .res_valid(res_valid4), .res_ready(res_ready & sel), .res_data(res_data4),
        .busy(busy4), .op_count(op_count4)
    );

    wire       o_cmd_ready = sel ? cmd_ready4 : cmd_ready1;
    wire       o_res_valid = sel ? res_valid4 : res_valid1;
    wire       o_busy      = sel ? busy4      : busy1;
    wire [7:0] o_alu_a     = sel ? alu_a4     : alu_a1;
    wire [7:0] o_alu_b     = sel ? alu_b4     : alu_b1;
    wire [1:0] o_alu_op    = sel ? alu_op4    : alu_op1;
    wire [7:0] o_res_data  = sel ? res_data4  : res_data1;
    wire [7:0] o_op_count  = sel ? op_count4  : op_count1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command with res_ready held high; returns the result and cycles spent waiting for res_valid.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic ua, output logic [7:0] data, output int lat);
        @(negedge clk);
        check("cmd_ready_before_cmd", 8'(o_cmd_ready), 8'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!o_res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        data = o_res_data;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, exp, acc_m, ea;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        logic       rua;
        int         lat;

        sel = 1'b0; rst_n1 = 1'b0; rst_n4 = 1'b0;
        cmd_valid = 1'b0; cmd_use_acc = 1'b0; res_ready = 1'b0;
        cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n1 = 1'b1;
        check("rst_res_valid", 8'(o_res_valid), 8'd0);
        check("rst_res_data", o_res_data, 8'h00);
        check("rst_alu_a", o_alu_a, 8'h00);
        check("rst_alu_b", o_alu_b, 8'h00);
        check("rst_alu_op", 8'(o_alu_op), 8'd0);
        check("rst_op_count", o_op_count, 8'h00);
        check("rst_cmd_ready", 8'(o_cmd_ready), 8'd1);
        check("rst_busy", 8'(o_busy), 8'd0);

        run_cmd(2'b10, 8'hF0, 8'h3C, 1'b0, d, lat);
        check("and_latency", 8'(lat), 8'd1);
        check("and_result", d, 8'h30);
        check("and_op_count", o_op_count, 8'h01);
        check("and_alu_a", o_alu_a, 8'hF0);
        check("and_alu_b", o_alu_b, 8'h3C);
        check("and_alu_op", 8'(o_alu_op), 8'd2);
        check("and_cmd_ready_after", 8'(o_cmd_ready), 8'd1);
        check("and_busy_after", 8'(o_busy), 8'd0);

        run_cmd(2'b11, 8'h01, 8'h80, 1'b0, d, lat);
        check("chain_or", d, 8'h81);
        run_cmd(2'b10, 8'hFF, 8'h0F, 1'b1, d, lat);
        check("chain_acc_alu_a", o_alu_a, 8'h81);
        check("chain_and_acc", d, 8'h01);
        run_cmd(2'b01, 8'h05, 8'h07, 1'b0, d, lat);
        check("chain_sub", d, 8'hFE);
        repeat (3) @(negedge clk);
        check("hold_alu_a", o_alu_a, 8'h05);
        check("hold_alu_b", o_alu_b, 8'h07);
        check("hold_alu_op", 8'(o_alu_op), 8'd1);
        check("chain_op_count", o_op_count, 8'h04);

        // Backpressure: result held while cmd_valid stays asserted with different fields.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h22; cmd_b = 8'h11; cmd_use_acc = 1'b0; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b11; cmd_a = 8'hAA; cmd_b = 8'hBB;
        lat = 0;
        while (!o_res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 8'(lat), 8'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", 8'(o_res_valid), 8'd1);
            check("bp_res_data", o_res_data, 8'h33);
            check("bp_cmd_ready", 8'(o_cmd_ready), 8'd0);
            check("bp_alu_a", o_alu_a, 8'h22);
            check("bp_op_count", o_op_count, 8'h04);
            @(negedge clk);
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_done_res_valid", 8'(o_res_valid), 8'd0);
        check("bp_done_op_count", o_op_count, 8'h05);
        check("bp_done_cmd_ready", 8'(o_cmd_ready), 8'd1);
        @(negedge clk);
        check("bp_single_handshake", o_op_count, 8'h05);

        // op_count wrap after 256 handshakes from reset.
        rst_n1 = 1'b0;
        @(negedge clk);
        rst_n1 = 1'b1;
        check("wrap_start_count", o_op_count, 8'h00);
        acc_m = 8'h00;
        for (int i = 0; i < 257; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rua = 1'($urandom_range(0, 1));
            ea  = rua ? acc_m : ra;
            exp = alu_model(ea, rb, rop);
            acc_m = exp;
            run_cmd(rop, ra, rb, rua, d, lat);
            check("wrap_result", d, exp);
            if (i == 255) check("wrap_count_256", o_op_count, 8'h00);
        end
        check("wrap_count_257", o_op_count, 8'h01);

        // SETTLE_CYCLES=4 instance: latency and mid-SETTLE reset.
        sel = 1'b1;
        @(negedge clk);
        rst_n4 = 1'b1;
        check("s4_rst_cmd_ready", 8'(o_cmd_ready), 8'd1);
        check("s4_rst_res_valid", 8'(o_res_valid), 8'd0);
        run_cmd(2'b11, 8'h55, 8'h0A, 1'b0, d, lat);
        check("s4_latency", 8'(lat), 8'd4);
        check("s4_or_result", d, 8'h5F);
        check("s4_op_count", o_op_count, 8'h01);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h20; cmd_b = 8'h20; cmd_use_acc = 1'b0; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("s4_settle_busy", 8'(o_busy), 8'd1);
        check("s4_settle_res_valid", 8'(o_res_valid), 8'd0);
        @(negedge clk);
        rst_n4 = 1'b0;
        @(negedge clk);
        rst_n4 = 1'b1;
        res_ready = 1'b0;
        check("s4_mid_rst_cmd_ready", 8'(o_cmd_ready), 8'd1);
        check("s4_mid_rst_busy", 8'(o_busy), 8'd0);
        check("s4_mid_rst_res_valid", 8'(o_res_valid), 8'd0);
        check("s4_mid_rst_res_data", o_res_data, 8'h00);
        check("s4_mid_rst_op_count", o_op_count, 8'h00);
        check("s4_mid_rst_alu_a", o_alu_a, 8'h00);
        repeat (6) @(negedge clk);
        check("s4_discarded", 8'(o_res_valid), 8'd0);
        check("s4_discard_count", o_op_count, 8'h00);

        run_cmd(2'b00, 8'hEE, 8'h11, 1'b1, d, lat);
        check("s4_acc_cleared_alu_a", o_alu_a, 8'h00);
        check("s4_acc_add", d, 8'h11);
        run_cmd(2'b00, 8'h10, 8'h01, 1'b0, d, lat);
        check("s4_add", d, 8'h11);
        check("s4_final_count", o_op_count, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
